// File: rtl/ag_pkg.sv
// Shared helpers for the ag_* access-pattern generators: word type, width mask,
// base checkerboard pattern and the per-index checkerboard word.
package ag_pkg;

  localparam int unsigned AG_MAX_WIDTH = 256;

  typedef logic [AG_MAX_WIDTH-1:0] ag_word_t;

  function automatic ag_word_t ag_width_mask(int unsigned width);
    ag_word_t m;
    m = '0;
    for (int unsigned i = 0; i < AG_MAX_WIDTH; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Base pattern P: even bit positions set, odd clear, limited to the word width.
  function automatic ag_word_t ag_base_pattern(int unsigned width);
    ag_word_t p;
    p = '0;
    for (int unsigned i = 0; i < AG_MAX_WIDTH; i++) begin
      if ((i < width) && (i[0] == 1'b0)) p[i] = 1'b1;
    end
    return p;
  endfunction

  function automatic ag_word_t checker_word(int unsigned width, int unsigned k, logic invert);
    ag_word_t w;
    w = ag_base_pattern(width);
    if (k[0] ^ invert) w = ~w & ag_width_mask(width);
    return w;
  endfunction

endpackage

// File: rtl/ag_checkerboard.sv
// Checkerboard write-pattern generator: LENGTH words alternating P / ~P, then sticky finished_o.
// Defining AG_CHECKERBOARD_INDEX_OUT_EN adds the wr_idx_o word-index output.
module ag_checkerboard
  import ag_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned LENGTH        = 16,
  parameter int unsigned INVERT_VALUES = 0
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             enbl_i,
  output logic [WIDTH-1:0] wr_data_o,
  output logic             wr_enbl_o,
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
  output logic [((LENGTH > 1) ? $clog2(LENGTH) : 1)-1:0] wr_idx_o,
`endif
  output logic             finished_o
);

  localparam int unsigned CNT_W = $clog2(LENGTH + 1);

  // Only two distinct words exist, so they are fixed at elaboration and chosen by cnt parity.
  localparam ag_word_t         EVEN_FULL = checker_word(WIDTH, 0, INVERT_VALUES != 0);
  localparam ag_word_t         ODD_FULL  = checker_word(WIDTH, 1, INVERT_VALUES != 0);
  localparam logic [WIDTH-1:0] EVEN_WORD = EVEN_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ODD_WORD  = ODD_FULL[WIDTH-1:0];
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LENGTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wr_enbl_q, wr_enbl_d;
  logic             finished_q, finished_d;

`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
  localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  logic [IDX_W-1:0] idx_q, idx_d;
`endif

  always_comb begin
    cnt_d      = cnt_q;
    data_d     = data_q;
    wr_enbl_d  = 1'b0;
    finished_d = finished_q;
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
    idx_d      = idx_q;
`endif
    if (cnt_q == CNT_LAST) begin
      finished_d = 1'b1;
    end else if (enbl_i) begin
      data_d    = cnt_q[0] ? ODD_WORD : EVEN_WORD;
      wr_enbl_d = 1'b1;
      cnt_d     = cnt_q + CNT_W'(1);
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
      idx_d     = IDX_W'(cnt_q);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q      <= '0;
      data_q     <= '0;
      wr_enbl_q  <= 1'b0;
      finished_q <= 1'b0;
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
      idx_q      <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      wr_enbl_q  <= wr_enbl_d;
      finished_q <= finished_d;
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
      idx_q      <= idx_d;
`endif
    end
  end

  assign wr_data_o  = data_q;
  assign wr_enbl_o  = wr_enbl_q;
  assign finished_o = finished_q;
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
  assign wr_idx_o   = idx_q;
`endif

endmodule

// File: tb/tb_ag_checkerboard.sv
// Self-checking bench for ag_checkerboard: three instances (plain, inverted, 5-bit single word)
// checked against a behavioural model of the checkerboard sequence.
module tb_ag_checkerboard;

  localparam int L0 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, en0, we0, fin0;
  logic [7:0] d0;
  logic       rst1_n, en1, we1, fin1;
  logic [7:0] d1;
  logic       rst2_n, en2, we2, fin2;
  logic [4:0] d2;
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
  logic [3:0] idx0, idx1;
  logic [0:0] idx2;
`endif

  int errors = 0;
  int checks = 0;

  int         m_k, m_idx;
  logic       m_we, m_fin;
  logic [7:0] m_data;

  ag_checkerboard #(.WIDTH(8), .LENGTH(L0), .INVERT_VALUES(0)) dut0 (
    .clk_i(clk), .arst_n_i(rst0_n), .enbl_i(en0), .wr_data_o(d0), .wr_enbl_o(we0),
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
    .wr_idx_o(idx0),
`endif
    .finished_o(fin0));

  ag_checkerboard #(.WIDTH(8), .LENGTH(L0), .INVERT_VALUES(1)) dut1 (
    .clk_i(clk), .arst_n_i(rst1_n), .enbl_i(en1), .wr_data_o(d1), .wr_enbl_o(we1),
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
    .wr_idx_o(idx1),
`endif
    .finished_o(fin1));

  ag_checkerboard #(.WIDTH(5), .LENGTH(1), .INVERT_VALUES(0)) dut2 (
    .clk_i(clk), .arst_n_i(rst2_n), .enbl_i(en2), .wr_data_o(d2), .wr_enbl_o(we2),
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
    .wr_idx_o(idx2),
`endif
    .finished_o(fin2));

  // Word k of a checkerboard: P has every even bit set; odd-parity words are all-ones minus P.
  function automatic int exp_word(int width, int k, int inv);
    longint p;
    p = 0;
    for (int i = 0; i < width; i += 2) p += longint'(1) << i;
    if (((k + inv) % 2) == 1) p = ((longint'(1) << width) - 1) - p;
    return int'(p);
  endfunction

  task automatic model_reset0();
    m_k = 0; m_idx = 0; m_we = 1'b0; m_fin = 1'b0; m_data = '0;
  endtask

  // Drive enable at a falling edge, let one rising edge happen, advance the model, return at the next falling edge.
  task automatic tick0(input logic en);
    en0 = en;
    @(posedge clk);
    if (m_k < L0) begin
      m_we = en;
      if (en) begin
        m_data = 8'(exp_word(8, m_k, 0));
        m_idx  = m_k;
        m_k++;
      end
    end else begin
      m_we  = 1'b0;
      m_fin = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset0();
    rst0_n = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    model_reset0();
  endtask

  task automatic test_reset();
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    @(negedge clk);
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    #1;
    checks++;
    if ({we0, fin0, d0} !== 10'd0) begin
      errors++; $display("[TB] FAIL reset dut0: got we/fin/data %b/%b/%h exp 0/0/00", we0, fin0, d0);
    end
    checks++;
    if ({we1, fin1, d1} !== 10'd0) begin
      errors++; $display("[TB] FAIL reset dut1: got we/fin/data %b/%b/%h exp 0/0/00", we1, fin1, d1);
    end
    checks++;
    if ({we2, fin2, d2} !== 7'd0) begin
      errors++; $display("[TB] FAIL reset dut2: got we/fin/data %b/%b/%h exp 0/0/00", we2, fin2, d2);
    end
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
    checks++;
    if ({idx0, idx1, idx2} !== 9'd0) begin
      errors++; $display("[TB] FAIL reset idx: got %h/%h/%h exp 0/0/0", idx0, idx1, idx2);
    end
`endif
    @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1; rst2_n = 1'b1;
    model_reset0();
  endtask

  task automatic test_full_run();
    int s;
    s = 0;
    for (int c = 0; c < L0 + 4; c++) begin
      tick0(1'b1);
      if (we0) s++;
      checks++;
      if ({we0, fin0, d0} !== {m_we, m_fin, m_data}) begin
        errors++;
        $display("[TB] FAIL full_run c=%0d: got we/fin/data %b/%b/%h exp %b/%b/%h",
                 c, we0, fin0, d0, m_we, m_fin, m_data);
      end
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
      checks++;
      if (idx0 !== 4'(m_idx)) begin
        errors++; $display("[TB] FAIL full_run_idx c=%0d: got %0d exp %0d", c, idx0, m_idx);
      end
`endif
    end
    checks++;
    if (s != L0) begin
      errors++; $display("[TB] FAIL full_run_count: got %0d strobes exp %0d", s, L0);
    end
    checks++;
    if ({we0, fin0, d0} !== {1'b0, 1'b1, 8'hAA}) begin
      errors++; $display("[TB] FAIL full_run_end: got we/fin/data %b/%b/%h exp 0/1/aa", we0, fin0, d0);
    end
  endtask

  task automatic test_pause();
    int s;
    logic en;
    pulse_reset0();
    s = 0;
    for (int c = 0; c < L0 + 6; c++) begin
      en = !((c >= 5) && (c < 8));
      tick0(en);
      if (we0) s++;
      checks++;
      if ({we0, fin0, d0} !== {m_we, m_fin, m_data}) begin
        errors++;
        $display("[TB] FAIL pause c=%0d: got we/fin/data %b/%b/%h exp %b/%b/%h",
                 c, we0, fin0, d0, m_we, m_fin, m_data);
      end
      if (!en) begin
        checks++;
        if ({we0, d0} !== {1'b0, 8'h55}) begin
          errors++; $display("[TB] FAIL pause_hold c=%0d: got we/data %b/%h exp 0/55", c, we0, d0);
        end
      end
    end
    checks++;
    if (s != L0) begin
      errors++; $display("[TB] FAIL pause_count: got %0d strobes exp %0d", s, L0);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    pulse_reset0();
    for (int c = 0; c < 10; c++) begin
      tick0(1'b1);
      checks++;
      if ({we0, d0} !== {m_we, m_data}) begin
        errors++; $display("[TB] FAIL mid_pre c=%0d: got we/data %b/%h exp %b/%h", c, we0, d0, m_we, m_data);
      end
    end
    rst0_n = 1'b0;
    #1;
    checks++;
    if ({we0, fin0, d0} !== 10'd0) begin
      errors++; $display("[TB] FAIL mid_abort: got we/fin/data %b/%b/%h exp 0/0/00", we0, fin0, d0);
    end
    @(negedge clk);
    rst0_n = 1'b1;
    model_reset0();
    s = 0;
    for (int c = 0; c < L0 + 3; c++) begin
      tick0(1'b1);
      if (we0) s++;
      if (c == 0) begin
        checks++;
        if ({we0, d0} !== {1'b1, 8'h55}) begin
          errors++; $display("[TB] FAIL mid_restart: got we/data %b/%h exp 1/55", we0, d0);
        end
      end
      checks++;
      if ({we0, fin0, d0} !== {m_we, m_fin, m_data}) begin
        errors++;
        $display("[TB] FAIL mid_rerun c=%0d: got we/fin/data %b/%b/%h exp %b/%b/%h",
                 c, we0, fin0, d0, m_we, m_fin, m_data);
      end
    end
    checks++;
    if ((s != L0) || (fin0 !== 1'b1)) begin
      errors++; $display("[TB] FAIL mid_count: got %0d strobes fin=%b exp %0d fin=1", s, fin0, L0);
    end
  endtask

  task automatic test_random();
    int s;
    pulse_reset0();
    s = 0;
    for (int c = 0; c < 150; c++) begin
      tick0(1'($urandom_range(0, 1)));
      if (we0) s++;
      checks++;
      if ({we0, fin0, d0} !== {m_we, m_fin, m_data}) begin
        errors++;
        $display("[TB] FAIL random c=%0d: got we/fin/data %b/%b/%h exp %b/%b/%h",
                 c, we0, fin0, d0, m_we, m_fin, m_data);
      end
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
      checks++;
      if (idx0 !== 4'(m_idx)) begin
        errors++; $display("[TB] FAIL random_idx c=%0d: got %0d exp %0d", c, idx0, m_idx);
      end
`endif
    end
    checks++;
    if (s != m_k) begin
      errors++; $display("[TB] FAIL random_count: got %0d strobes exp %0d", s, m_k);
    end
  endtask

  task automatic test_invert();
    int s;
    s = 0;
    en1 = 1'b1;
    for (int c = 0; c < L0 + 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (we1 && fin1) begin
        errors++; $display("[TB] FAIL invert_overlap c=%0d: got we=1 fin=1 exp not both", c);
      end
      if (we1) begin
        checks++;
        if (d1 !== 8'(exp_word(8, s, 1))) begin
          errors++; $display("[TB] FAIL invert_word k=%0d: got %h exp %h", s, d1, 8'(exp_word(8, s, 1)));
        end
`ifdef AG_CHECKERBOARD_INDEX_OUT_EN
        checks++;
        if (idx1 !== 4'(s)) begin
          errors++; $display("[TB] FAIL invert_idx k=%0d: got %0d exp %0d", s, idx1, s);
        end
`endif
        s++;
      end
    end
    checks++;
    if ((s != L0) || ({we1, fin1, d1} !== {1'b0, 1'b1, 8'h55})) begin
      errors++;
      $display("[TB] FAIL invert_end: got %0d strobes we/fin/data %b/%b/%h exp %0d 0/1/55", s, we1, fin1, d1, L0);
    end
  endtask

  task automatic test_length1();
    int s;
    s = 0;
    for (int c = 0; c < 8; c++) begin
      en2 = ((c % 2) == 0);
      @(posedge clk);
      @(negedge clk);
      if (we2) begin
        checks++;
        if (d2 !== 5'(exp_word(5, s, 0))) begin
          errors++; $display("[TB] FAIL len1_word: got %h exp %h", d2, 5'(exp_word(5, s, 0)));
        end
        s++;
      end
    end
    checks++;
    if ((s != 1) || ({we2, fin2, d2} !== {1'b0, 1'b1, 5'h15})) begin
      errors++; $display("[TB] FAIL len1_end: got %0d strobes we/fin/data %b/%b/%h exp 1 0/1/15", s, we2, fin2, d2);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_pause();
    test_reset_mid();
    test_random();
    test_invert();
    test_length1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ag_checkerboard.md
Name: ag_checkerboard

Overview:
- Pattern generator ("ag" = access generator) for the eMMC stress/self-test datapath.
- When enabled, emits exactly LENGTH write words forming a checkerboard:
  - bits alternate within each word;
  - each successive word is the bitwise inverse of the previous one.
- Sits upstream of the write buffer/FIFO; the FSM sequencer watches finished_o to advance to the next test phase.

Parameters:
- WIDTH, 8: data word width in bits; must be >= 1.
- LENGTH, 16: number of words emitted per run; must be >= 1.
- INVERT_VALUES, 0: 0 starts the run with pattern P; 1 starts with ~P (complementary board).

Ports:
- clk_i  in  1  single system clock, rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- enbl_i  in  1  generation enable; level-sensitive, sampled each rising edge.
- wr_data_o  out  WIDTH  current pattern word; valid when wr_enbl_o=1.
- wr_enbl_o  out  1  write strobe; one word transferred per cycle it is high.
- finished_o  out  1  run complete; sticky until reset.

Behaviour:
- Base pattern P: bit i = 1 for even i, 0 for odd i (WIDTH=8 -> 8'h55; WIDTH=5 -> 5'h15).
- Word k (k = 0..LENGTH-1) = P when (k[0] XOR INVERT_VALUES) = 0, otherwise ~P.
- Internal word counter cnt, width $clog2(LENGTH+1), range 0..LENGTH.
- All outputs are registered.
- Reset (arst_n_i=0, asynchronous, immediate):
  - cnt=0, wr_enbl_o=0, wr_data_o=0, finished_o=0.
  - Deassertion is expected to be synchronised externally.
- Each rising edge, when not in reset:
  - enbl_i=1 and cnt<LENGTH: wr_data_o<=word(cnt), wr_enbl_o<=1, cnt<=cnt+1.
  - enbl_i=0 and cnt<LENGTH: wr_enbl_o<=0; wr_data_o and cnt hold (pause, no words skipped).
  - cnt==LENGTH: wr_enbl_o<=0, finished_o<=1, wr_data_o holds the last word; enbl_i is ignored.
- Latency:
  - First word appears one edge after the first edge at which enbl_i=1.
  - With enbl_i held high: wr_enbl_o is high for exactly LENGTH consecutive cycles.
  - finished_o rises on the edge where wr_enbl_o falls after the last word.
- finished_o and wr_enbl_o are never high in the same cycle.
- No restart without reset. Reset mid-run aborts the run; the next run starts again at word 0.
- LENGTH=1: a single word, then finished_o.

Optional Feature:
- Macro: AG_CHECKERBOARD_INDEX_OUT_EN.
- Defined:
  - Adds output port wr_idx_o, width $clog2(LENGTH) (minimum 1).
  - wr_idx_o is the registered index k of the word on wr_data_o, updated together with wr_data_o; reset value 0.
- Undefined: the port does not exist and there is no related logic. Pattern and timing are identical in both builds.

Decomposition:
- Package ag_pkg holds:
  - function checker_word(width, k, invert), returning the masked word;
  - the base-pattern constant generator shared with the other ag_* generators.
- No sub-module: the counter and output registers live in ag_checkerboard.

Test Plan:
- WIDTH=8, LENGTH=16, INVERT_VALUES=0, enbl_i=1 after reset release -> 16 strobe cycles with data 55,AA,55,AA,...,AA; then wr_enbl_o=0, finished_o=1, wr_data_o stays AA.
- Same run with INVERT_VALUES=1 -> sequence AA,55,...,55; finished_o=1 after the 16th word.
- enbl_i deasserted for 3 cycles after word 4 -> wr_enbl_o=0 for those cycles, wr_data_o holds 55, then resumes with word 5=AA; the total strobe count is still 16.
- arst_n_i pulsed low after word 9 -> all outputs 0 immediately; after release, words restart at 55 and 16 full words precede finished_o.
- WIDTH=5, LENGTH=1 -> one strobe with 5'h15, then finished_o=1. After finished, toggling enbl_i produces no further strobes.
- With AG_CHECKERBOARD_INDEX_OUT_EN defined, WIDTH=8, LENGTH=16 -> wr_idx_o reads 0..15 in lockstep with the strobes and holds 15 after finished.
